// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package load_store_unit_pkg;

    localparam int unsigned WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } lsu_state_e;

    // RV32I funct3 width/sign codes for loads and stores
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // True when the access is misaligned for its width or uses an undefined funct3
    function automatic logic access_fault(input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic fault;
        fault = 1'b0;
        case (funct3)
            LB:      fault = 1'b0;
            LH:      fault = addr_lo[0];
            LW:      fault = |addr_lo;
            LBU:     fault = is_store;
            LHU:     fault = is_store | addr_lo[0];
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Selects the addressed byte/half/word from a read word and sign- or zero-extends it.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [WIDTH-1:0] word,
    input  logic [1:0]       addr_lo,
    input  logic [2:0]       funct3,
    output logic [WIDTH-1:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane extraction followed by width/sign selection
    always_comb begin
        result    = '0;
        byte_lane = 8'(word >> {addr_lo, 3'b000});
        half_lane = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            LB:      result = {{24{byte_lane[7]}}, byte_lane};
            LBU:     result = {24'd0, byte_lane};
            LH:      result = {{16{half_lane[15]}}, half_lane};
            LHU:     result = {16'd0, half_lane};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: req/gnt/rvalid handshake, byte enables, load alignment, stall.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    input  logic             is_store_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             done_o,
    output logic             stall_o,
    output logic             misaligned_o,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic [WIDTH-1:0] dmem_addr_o,
    output logic [WIDTH-1:0] dmem_wdata_o,
    output logic [3:0]       dmem_be_o,
    input  logic             dmem_gnt_i,
    input  logic             dmem_rvalid_i,
    input  logic [WIDTH-1:0] dmem_rdata_i
);

    lsu_state_e       state_q, state_d;
    logic             accept_c;
    logic             capture_c;
    logic             fault_c;
    logic [3:0]       be_c;
    logic [WIDTH-1:0] st_wdata_c;
    logic [WIDTH-1:0] load_result;

    logic             is_store_q;
    logic [2:0]       funct3_q;
    logic [WIDTH-1:0] addr_q;
    logic [3:0]       be_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] rdata_q;
    logic             done_q;
    logic             mis_q;
    logic             req_q;

    assign fault_c = access_fault(is_store_i, funct3_i, addr_i[1:0]);

    // Byte enables and lane-replicated store data for the incoming request
    always_comb begin
        be_c       = 4'b1111;
        st_wdata_c = '0;
        if (is_store_i) begin
            case (funct3_i)
                SB: begin
                    be_c       = 4'b0001 << addr_i[1:0];
                    st_wdata_c = {4{wdata_i[7:0]}};
                end
                SH: begin
                    be_c       = 4'b0011 << {addr_i[1], 1'b0};
                    st_wdata_c = {2{wdata_i[15:0]}};
                end
                default: begin
                    be_c       = 4'b1111;
                    st_wdata_c = wdata_i;
                end
            endcase
        end
    end

    // Next-state logic; requests are only taken in IDLE
    always_comb begin
        state_d   = state_q;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    accept_c = 1'b1;
                    state_d  = fault_c ? ERR : REQ;
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    state_d = is_store_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    capture_c = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the accepted request; held stable through REQ until grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= '0;
            be_q       <= 4'd0;
            wdata_q    <= '0;
        end else if (accept_c) begin
            is_store_q <= is_store_i;
            funct3_q   <= funct3_i;
            addr_q     <= addr_i;
            be_q       <= be_c;
            wdata_q    <= st_wdata_c;
        end
    end

    // Registered status outputs, request strobe and load result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            done_q <= (state_d == DONE) || (state_d == ERR);
            mis_q  <= (state_d == ERR);
            req_q  <= (state_d == REQ);
            if (capture_c) begin
                rdata_q <= load_result;
            end
        end
    end

    lsu_load_align u_load_align (
        .word    (dmem_rdata_i),
        .addr_lo (addr_q[1:0]),
        .funct3  (funct3_q),
        .result  (load_result)
    );

    assign rdata_o      = rdata_q;
    assign done_o       = done_q;
    assign misaligned_o = mis_q;
    assign stall_o      = req_valid_i && !done_q;
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = is_store_q;
    assign dmem_addr_o  = {addr_q[WIDTH-1:2], 2'b00};
    assign dmem_wdata_o = wdata_q;
    assign dmem_be_o    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a scripted grant/rvalid memory responder.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        is_store_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        stall_o;
    logic        misaligned_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    int n_checks;
    int n_fail;

    int          r_done_cyc;
    int          r_req_cyc;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_we;
    logic        r_stable;
    logic        r_stall_ok;
    logic        r_mis;
    logic [31:0] r_rdata;

    load_store_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid_i),
        .is_store_i    (is_store_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .rdata_o       (rdata_o),
        .done_o        (done_o),
        .stall_o       (stall_o),
        .misaligned_o  (misaligned_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one access; gd = request cycles without grant, rvd = wait cycles before rvalid
    task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int gd, input int rvd,
                          input logic [31:0] word);
        int   req_cnt;
        int   wait_cnt;
        logic granted;
        req_cnt    = 0;
        wait_cnt   = 0;
        granted    = 1'b0;
        r_done_cyc = -1;
        r_stable   = 1'b1;
        r_stall_ok = 1'b1;
        r_mis      = 1'b0;
        r_rdata    = 32'd0;
        r_addr     = 32'd0;
        r_wdata    = 32'd0;
        r_be       = 4'd0;
        r_we       = 1'b0;
        req_valid_i  = 1'b1;
        is_store_i   = st;
        funct3_i     = f3;
        addr_i       = a;
        wdata_i      = wd;
        dmem_rdata_i = word;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            step();
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = 1'b0;
            if (stall_o != !done_o) r_stall_ok = 1'b0;
            if (done_o) begin
                r_done_cyc = cyc;
                r_mis      = misaligned_o;
                r_rdata    = rdata_o;
                break;
            end
            if (dmem_req_o) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    r_addr  = dmem_addr_o;
                    r_wdata = dmem_wdata_o;
                    r_be    = dmem_be_o;
                    r_we    = dmem_we_o;
                end else if (dmem_addr_o != r_addr || dmem_wdata_o != r_wdata ||
                             dmem_be_o != r_be || dmem_we_o != r_we) begin
                    r_stable = 1'b0;
                end
                if (req_cnt == gd + 1) begin
                    dmem_gnt_i = 1'b1;
                    granted    = 1'b1;
                end
            end else if (granted && !st) begin
                wait_cnt++;
                if (wait_cnt == rvd + 1) dmem_rvalid_i = 1'b1;
            end
        end
        r_req_cyc   = req_cnt;
        req_valid_i = 1'b0;
        step();
        check("done_one_cycle", 32'(done_o), 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        req_valid_i   = 1'b0;
        is_store_i    = 1'b0;
        funct3_i      = 3'd0;
        addr_i        = 32'd0;
        wdata_i       = 32'd0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'd0;
        step();
        step();
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_mis", 32'(misaligned_o), 32'd0);
        check("rst_req", 32'(dmem_req_o), 32'd0);
        rst_n = 1'b1;
        step();

        // SW, immediate grant
        access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'd0);
        check("sw_be", 32'(r_be), 32'hF);
        check("sw_addr", r_addr, 32'h100);
        check("sw_we", 32'(r_we), 32'd1);
        check("sw_wdata", r_wdata, 32'hDEADBEEF);
        check("sw_req_cycles", 32'(r_req_cyc), 32'd1);
        check("sw_latency", 32'(r_done_cyc), 32'd2);
        check("sw_stall", 32'(r_stall_ok), 32'd1);
        check("sw_mis", 32'(r_mis), 32'd0);

        // SB to top byte lane
        access(1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 32'd0);
        check("sb_be", 32'(r_be), 32'h8);
        check("sb_wdata", r_wdata, 32'hA5A5A5A5);
        check("sb_addr", r_addr, 32'h100);
        check("sb_latency", 32'(r_done_cyc), 32'd2);

        // SH to upper half
        access(1'b1, 3'b001, 32'h102, 32'h1234BEEF, 0, 0, 32'd0);
        check("sh_be", 32'(r_be), 32'hC);
        check("sh_wdata", r_wdata, 32'hBEEFBEEF);

        // Loads from 0x11F08822 with three wait cycles
        access(1'b0, 3'b000, 32'h102, 32'd0, 0, 3, 32'h11F08822);
        check("lb_rdata", r_rdata, 32'hFFFFFFF0);
        check("lb_latency", 32'(r_done_cyc), 32'd6);
        check("lb_be", 32'(r_be), 32'hF);
        check("lb_we", 32'(r_we), 32'd0);
        check("lb_wdata", r_wdata, 32'd0);
        check("lb_stall", 32'(r_stall_ok), 32'd1);
        access(1'b0, 3'b100, 32'h102, 32'd0, 0, 3, 32'h11F08822);
        check("lbu_rdata", r_rdata, 32'h000000F0);
        access(1'b0, 3'b101, 32'h102, 32'd0, 0, 3, 32'h11F08822);
        check("lhu_rdata", r_rdata, 32'h000011F0);
        access(1'b0, 3'b001, 32'h100, 32'd0, 0, 0, 32'h11F08822);
        check("lh_rdata", r_rdata, 32'hFFFF8822);

        // LW zero-wait
        access(1'b0, 3'b010, 32'h104, 32'd0, 0, 0, 32'h12345678);
        check("lw_rdata", r_rdata, 32'h12345678);
        check("lw_latency", 32'(r_done_cyc), 32'd3);
        check("lw_addr", r_addr, 32'h104);

        // Misaligned / illegal accesses
        access(1'b0, 3'b010, 32'h101, 32'd0, 0, 0, 32'hFFFFFFFF);
        check("lw_mis_req", 32'(r_req_cyc), 32'd0);
        check("lw_mis_latency", 32'(r_done_cyc), 32'd1);
        check("lw_mis_flag", 32'(r_mis), 32'd1);
        check("lw_mis_rdata", r_rdata, 32'h12345678);
        access(1'b1, 3'b001, 32'h101, 32'h5555, 0, 0, 32'd0);
        check("sh_mis_flag", 32'(r_mis), 32'd1);
        check("sh_mis_req", 32'(r_req_cyc), 32'd0);
        access(1'b0, 3'b011, 32'h100, 32'd0, 0, 0, 32'd0);
        check("ld_illegal_flag", 32'(r_mis), 32'd1);
        access(1'b1, 3'b100, 32'h100, 32'd0, 0, 0, 32'd0);
        check("st_illegal_flag", 32'(r_mis), 32'd1);
        check("st_illegal_req", 32'(r_req_cyc), 32'd0);

        // Grant withheld for five request cycles
        access(1'b1, 3'b010, 32'h208, 32'hCAFEBABE, 5, 0, 32'd0);
        check("slow_req_cycles", 32'(r_req_cyc), 32'd6);
        check("slow_stable", 32'(r_stable), 32'd1);
        check("slow_addr", r_addr, 32'h208);
        check("slow_latency", 32'(r_done_cyc), 32'd7);

        // Reset while waiting for read data, then a stray rvalid
        req_valid_i = 1'b1;
        is_store_i  = 1'b0;
        funct3_i    = 3'b010;
        addr_i      = 32'h200;
        step();
        check("rstw_req_on", 32'(dmem_req_o), 32'd1);
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        check("rstw_wait_req", 32'(dmem_req_o), 32'd0);
        rst_n = 1'b0;
        step();
        check("rstw_req_off", 32'(dmem_req_o), 32'd0);
        check("rstw_rdata", rdata_o, 32'd0);
        rst_n         = 1'b1;
        req_valid_i   = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h12345678;
        step();
        dmem_rvalid_i = 1'b0;
        check("stray_rdata", rdata_o, 32'd0);
        check("stray_done", 32'(done_o), 32'd0);
        step();
        check("stray_done2", 32'(done_o), 32'd0);
        check("stray_req", 32'(dmem_req_o), 32'd0);
        access(1'b0, 3'b010, 32'h300, 32'd0, 0, 0, 32'hCAFEF00D);
        check("post_rst_rdata", r_rdata, 32'hCAFEF00D);
        check("post_rst_latency", 32'(r_done_cyc), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
